// File: rtl/icache_refill_pkg.sv
// rtl/icache_refill_pkg.sv - shared types and helpers for the icache refill unit
package icache_refill_pkg;

  localparam int BEAT_W = 64;

  typedef logic [BEAT_W-1:0] beat_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL,
    DRAIN
  } refill_state_t;

  function automatic logic [31:0] block_align(input logic [31:0] addr, input int unsigned block_bytes);
    return addr & ~(32'(block_bytes) - 32'd1);
  endfunction

endpackage

// File: rtl/refill_beat_fifo.sv
// rtl/refill_beat_fifo.sv - small synchronous beat FIFO with fall-through head and flush
module refill_beat_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/icache_refill_unit.sv
// rtl/icache_refill_unit.sv - L1 icache refill engine: burst read, beat buffering, abort handling
// Optional perf counters under ICACHE_REFILL_PERF_EN.
module icache_refill_unit #(
  parameter int B      = 64,
  parameter int BEAT_W = icache_refill_pkg::BEAT_W,
  parameter int FIFO_D = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              miss_req_i,
  input  logic [31:0]       miss_addr_i,
  input  logic              abort_i,
  input  logic              ic_repl_permit_i,
  output logic [BEAT_W-1:0] rep_word_o,
  output logic              l2_repl_ready_o,
  output logic              mem_req_o,
  output logic [31:0]       mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [BEAT_W-1:0] mem_rdata_i,
  output logic              mem_rready_o,
  output logic              refill_busy_o,
  output logic              refill_done_o
`ifdef ICACHE_REFILL_PERF_EN
  ,
  output logic [31:0]       perf_refills_o,
  output logic [31:0]       perf_stall_cyc_o,
  output logic [31:0]       perf_aborts_o
`endif
);
  import icache_refill_pkg::*;

  localparam int BEATS = B * 8 / BEAT_W;
  localparam int CW    = $clog2(BEATS) + 1;
  localparam logic [CW-1:0] BEATS_C = CW'(BEATS);

  refill_state_t     state_q, state_d;
  logic [31:0]       addr_q;
  logic [CW-1:0]     rx_cnt_q, tx_cnt_q;
  logic [BEAT_W-1:0] head;
  logic              fifo_full, fifo_empty, fifo_flush;
  logic              push, pop, beat_acc, rx_full_next;

  refill_beat_fifo #(
    .DEPTH (FIFO_D),
    .WIDTH (BEAT_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .flush_i (fifo_flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (mem_rdata_i),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign l2_repl_ready_o = (state_q == FILL) && !fifo_empty;
  assign pop             = l2_repl_ready_o && ic_repl_permit_i;
  // Beats beyond the block are never requested, so stop accepting once all have arrived.
  assign mem_rready_o    = (state_q == DRAIN) ||
                           ((state_q == FILL) && (rx_cnt_q != BEATS_C) && (!fifo_full || pop));
  assign beat_acc        = mem_rvalid_i && mem_rready_o;
  assign push            = beat_acc && (state_q == FILL);
  assign rx_full_next    = ((rx_cnt_q + CW'(beat_acc)) == BEATS_C);
  assign rep_word_o      = l2_repl_ready_o ? head : '0;
  assign mem_req_o       = (state_q == REQ);
  assign mem_addr_o      = addr_q;
  assign refill_busy_o   = (state_q != IDLE);

  always_comb begin
    state_d       = state_q;
    refill_done_o = 1'b0;
    fifo_flush    = 1'b0;
    case (state_q)
      IDLE: begin
        fifo_flush = 1'b1;
        if (miss_req_i && !abort_i) state_d = REQ;
      end
      REQ: begin
        if (mem_gnt_i)    state_d = abort_i ? DRAIN : FILL;
        else if (abort_i) state_d = IDLE;
      end
      FILL: begin
        if (abort_i) begin
          fifo_flush = 1'b1;
          state_d    = rx_full_next ? IDLE : DRAIN;
        end else if (pop && (tx_cnt_q == BEATS_C - CW'(1))) begin
          refill_done_o = 1'b1;
          state_d       = IDLE;
        end
      end
      DRAIN: begin
        fifo_flush = 1'b1;
        if (rx_full_next) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && (state_d == REQ)) begin
        addr_q   <= block_align(miss_addr_i, B);
        rx_cnt_q <= '0;
        tx_cnt_q <= '0;
      end else begin
        if (beat_acc) rx_cnt_q <= rx_cnt_q + 1'b1;
        if (pop)      tx_cnt_q <= tx_cnt_q + 1'b1;
      end
    end
  end

`ifdef ICACHE_REFILL_PERF_EN
  logic abort_evt;
  assign abort_evt = abort_i && ((state_q == REQ) || (state_q == FILL));

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      perf_refills_o   <= '0;
      perf_stall_cyc_o <= '0;
      perf_aborts_o    <= '0;
    end else begin
      if (refill_done_o && (perf_refills_o != '1))     perf_refills_o   <= perf_refills_o + 1'b1;
      if (refill_busy_o && (perf_stall_cyc_o != '1))   perf_stall_cyc_o <= perf_stall_cyc_o + 1'b1;
      if (abort_evt && (perf_aborts_o != '1))          perf_aborts_o    <= perf_aborts_o + 1'b1;
    end
  end
`endif

  // Response beats may only arrive while a burst is outstanding.
  assert property (@(posedge clk_i) disable iff (!reset_i)
    mem_rvalid_i |-> ((state_q == FILL) || (state_q == DRAIN)));

endmodule

// File: tb/tb_icache_refill_unit.sv
// tb/tb_icache_refill_unit.sv - directed self-checking bench for icache_refill_unit
module tb_icache_refill_unit;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        miss_req_i;
  logic [31:0] miss_addr_i;
  logic        abort_i;
  logic        ic_repl_permit_i;
  logic [63:0] rep_word_o;
  logic        l2_repl_ready_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;
  logic        mem_rready_o;
  logic        refill_busy_o;
  logic        refill_done_o;
`ifdef ICACHE_REFILL_PERF_EN
  logic [31:0] perf_refills_o;
  logic [31:0] perf_stall_cyc_o;
  logic [31:0] perf_aborts_o;
`endif

  int checks   = 0;
  int failures = 0;

  icache_refill_unit dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .miss_req_i       (miss_req_i),
    .miss_addr_i      (miss_addr_i),
    .abort_i          (abort_i),
    .ic_repl_permit_i (ic_repl_permit_i),
    .rep_word_o       (rep_word_o),
    .l2_repl_ready_o  (l2_repl_ready_o),
    .mem_req_o        (mem_req_o),
    .mem_addr_o       (mem_addr_o),
    .mem_gnt_i        (mem_gnt_i),
    .mem_rvalid_i     (mem_rvalid_i),
    .mem_rdata_i      (mem_rdata_i),
    .mem_rready_o     (mem_rready_o),
    .refill_busy_o    (refill_busy_o),
    .refill_done_o    (refill_done_o)
`ifdef ICACHE_REFILL_PERF_EN
    ,
    .perf_refills_o   (perf_refills_o),
    .perf_stall_cyc_o (perf_stall_cyc_o),
    .perf_aborts_o    (perf_aborts_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [63:0] beat_val(input logic [7:0] base, input int idx);
    logic [7:0] b;
    b = base + 8'(idx);
    return {b, 48'h0123_4567_89AB, b};
  endfunction

  // Drives one full refill; beats are checked in order and the done pulse on the last consume.
  task automatic run_refill(input logic [31:0] addr, input logic [31:0] exp_addr, input logic [7:0] base,
                            input int gnt_delay, input int stall_at, input int stall_len, output int lat);
    int sent, got, stalled, cyc;
    logic cons;
    sent = 0; got = 0; stalled = 0; cyc = 0; lat = -1;
    @(negedge clk_i);
    miss_req_i = 1'b1; miss_addr_i = addr; abort_i = 1'b0; mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0; ic_repl_permit_i = 1'b1;
    #1;
    checks++;
    if (refill_busy_o !== 1'b0) begin
      failures++; $display("FAIL busy_before_miss got=%0b exp=0", refill_busy_o);
    end
    for (int i = 0; i <= gnt_delay; i++) begin
      @(negedge clk_i);
      miss_req_i = 1'b0; mem_gnt_i = (i == gnt_delay); cyc++;
      #1;
      checks++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== exp_addr) begin
        failures++; $display("FAIL req_phase req=%0b addr=%h exp_addr=%h", mem_req_o, mem_addr_o, exp_addr);
      end
    end
    for (int k = 0; k < 64 && got < 8; k++) begin
      @(negedge clk_i);
      mem_gnt_i = 1'b0;
      mem_rvalid_i = (sent < 8);
      mem_rdata_i = beat_val(base, sent);
      ic_repl_permit_i = !(got >= stall_at && stalled < stall_len);
      cyc++;
      #1;
      if (!ic_repl_permit_i) stalled++;
      if (mem_rvalid_i && mem_rready_o) sent++;
      cons = l2_repl_ready_o && ic_repl_permit_i;
      if (l2_repl_ready_o) begin
        checks++;
        if (rep_word_o !== beat_val(base, got)) begin
          failures++; $display("FAIL beat_order idx=%0d got=%h exp=%h", got, rep_word_o, beat_val(base, got));
        end
      end
      if (stall_len >= 3 && !ic_repl_permit_i && stalled == stall_len) begin
        checks++;
        if (mem_rready_o !== 1'b0 || l2_repl_ready_o !== 1'b1) begin
          failures++; $display("FAIL backpressure rready=%0b ready=%0b exp rready=0 ready=1", mem_rready_o, l2_repl_ready_o);
        end
      end
      if (cons) got++;
      checks++;
      if (refill_done_o !== (cons && got == 8)) begin
        failures++; $display("FAIL done_pulse got=%0b exp=%0b at beat %0d", refill_done_o, (cons && got == 8), got);
      end
      if (refill_done_o) lat = cyc;
    end
    mem_rvalid_i = 1'b0;
    checks++;
    if (got != 8 || sent != 8) begin
      failures++; $display("FAIL refill_complete consumed=%0d sent=%0d exp=8", got, sent);
    end
  endtask

  task automatic test_reset;
    reset_i = 1'b0; miss_req_i = 1'b0; miss_addr_i = '0; abort_i = 1'b0;
    ic_repl_permit_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (2) @(negedge clk_i);
    #1;
    checks++;
    if ({mem_req_o, mem_rready_o, l2_repl_ready_o, refill_busy_o, refill_done_o} !== 5'b0 ||
        mem_addr_o !== 32'h0 || rep_word_o !== 64'h0) begin
      failures++; $display("FAIL reset_outputs req=%0b addr=%h word=%h", mem_req_o, mem_addr_o, rep_word_o);
    end
    @(negedge clk_i);
    reset_i = 1'b1;
  endtask

  task automatic test_basic;
    int lat;
    run_refill(32'h0000_1234, 32'h0000_1200, 8'hA0, 2, 99, 0, lat);
    checks++;
    if (lat != 12) begin
      failures++; $display("FAIL basic_latency got=%0d exp=12", lat);
    end
  endtask

  task automatic test_backpressure;
    int lat;
    run_refill(32'h0000_2FFC, 32'h0000_2FC0, 8'h30, 0, 2, 5, lat);
  endtask

  task automatic test_abort_req;
    @(negedge clk_i);
    miss_req_i = 1'b1; miss_addr_i = 32'h0000_2000; abort_i = 1'b0; mem_gnt_i = 1'b0;
    @(negedge clk_i);
    miss_req_i = 1'b0; abort_i = 1'b1;
    #1;
    checks++;
    if (mem_req_o !== 1'b1) begin
      failures++; $display("FAIL abort_req_req_held got=%0b exp=1", mem_req_o);
    end
    @(negedge clk_i);
    abort_i = 1'b0;
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || refill_busy_o !== 1'b0 || refill_done_o !== 1'b0) begin
      failures++; $display("FAIL abort_req_idle req=%0b busy=%0b done=%0b exp 0 0 0", mem_req_o, refill_busy_o, refill_done_o);
    end
    // miss together with abort must be ignored
    @(negedge clk_i);
    miss_req_i = 1'b1; abort_i = 1'b1;
    @(negedge clk_i);
    miss_req_i = 1'b0; abort_i = 1'b0;
    #1;
    checks++;
    if (refill_busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
      failures++; $display("FAIL miss_with_abort busy=%0b req=%0b exp 0 0", refill_busy_o, mem_req_o);
    end
  endtask

  task automatic test_abort_fill;
    @(negedge clk_i);
    miss_req_i = 1'b1; miss_addr_i = 32'h0000_4010; ic_repl_permit_i = 1'b1;
    @(negedge clk_i);
    miss_req_i = 1'b0; mem_gnt_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = beat_val(8'h50, i);
    end
    @(negedge clk_i);
    mem_rvalid_i = 1'b0; abort_i = 1'b1;
    #1;
    checks++;
    if (refill_done_o !== 1'b0) begin
      failures++; $display("FAIL abort_fill_done got=%0b exp=0", refill_done_o);
    end
    for (int i = 3; i < 8; i++) begin
      @(negedge clk_i);
      abort_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = beat_val(8'h50, i);
      #1;
      checks++;
      if (l2_repl_ready_o !== 1'b0 || mem_rready_o !== 1'b1 || refill_done_o !== 1'b0 || refill_busy_o !== 1'b1) begin
        failures++; $display("FAIL drain beat=%0d ready=%0b rready=%0b done=%0b busy=%0b exp 0 1 0 1",
                             i, l2_repl_ready_o, mem_rready_o, refill_done_o, refill_busy_o);
      end
    end
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    #1;
    checks++;
    if (refill_busy_o !== 1'b0 || refill_done_o !== 1'b0) begin
      failures++; $display("FAIL drain_exit busy=%0b done=%0b exp 0 0", refill_busy_o, refill_done_o);
    end
  endtask

  task automatic test_reset_fill;
    int lat;
    @(negedge clk_i);
    miss_req_i = 1'b1; miss_addr_i = 32'h0000_6000; ic_repl_permit_i = 1'b1;
    @(negedge clk_i);
    miss_req_i = 1'b0; mem_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = beat_val(8'h60, i);
    end
    @(negedge clk_i);
    mem_rvalid_i = 1'b0; ic_repl_permit_i = 1'b0;
    #1;
    checks++;
    if (refill_busy_o !== 1'b1 || l2_repl_ready_o !== 1'b1) begin
      failures++; $display("FAIL pre_reset_busy busy=%0b ready=%0b exp 1 1", refill_busy_o, l2_repl_ready_o);
    end
    #1 reset_i = 1'b0;
    #1;
    checks++;
    if ({mem_req_o, mem_rready_o, l2_repl_ready_o, refill_busy_o, refill_done_o} !== 5'b0 ||
        mem_addr_o !== 32'h0 || rep_word_o !== 64'h0) begin
      failures++; $display("FAIL async_reset req=%0b rready=%0b ready=%0b busy=%0b addr=%h word=%h",
                           mem_req_o, mem_rready_o, l2_repl_ready_o, refill_busy_o, mem_addr_o, rep_word_o);
    end
    @(negedge clk_i);
    reset_i = 1'b1;
    run_refill(32'h0000_8008, 32'h0000_8000, 8'hC0, 1, 99, 0, lat);
  endtask

  task automatic test_back_to_back;
    int lat1, lat2;
    run_refill(32'hFFFF_FFC7, 32'hFFFF_FFC0, 8'h10, 0, 99, 0, lat1);
    run_refill(32'h0000_A080, 32'h0000_A080, 8'h20, 0, 99, 0, lat2);
    checks++;
    if (lat1 != 10 || lat2 != 10) begin
      failures++; $display("FAIL min_latency lat1=%0d lat2=%0d exp=10", lat1, lat2);
    end
  endtask

`ifdef ICACHE_REFILL_PERF_EN
  task automatic test_perf;
    int lat;
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b1;
    run_refill(32'h0000_0100, 32'h0000_0100, 8'h70, 0, 99, 0, lat);
    run_refill(32'h0000_0140, 32'h0000_0140, 8'h80, 0, 99, 0, lat);
    @(negedge clk_i);
    miss_req_i = 1'b1; miss_addr_i = 32'h0000_0180;
    @(negedge clk_i);
    miss_req_i = 1'b0; abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    #1;
    checks++;
    if (perf_refills_o !== 32'd2 || perf_aborts_o !== 32'd1 || perf_stall_cyc_o !== 32'd21) begin
      failures++; $display("FAIL perf refills=%0d aborts=%0d stall=%0d exp 2 1 21",
                           perf_refills_o, perf_aborts_o, perf_stall_cyc_o);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_abort_req();
    test_abort_fill();
    test_reset_fill();
    test_back_to_back();
`ifdef ICACHE_REFILL_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
